// File: rtl/mips32_instr_encoder.sv
// mips32_instr_encoder: turns symbolic micro-op requests into MIPS32
// instruction words. Each word leaves with the instruction-memory byte
// address it belongs at. The block fills instruction memory during
// bring-up and self-test. Valid/ready on both sides, latency 1, full
// throughput when the consumer is always ready, capacity limited to DEPTH.
module mips32_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0040_0000,
    parameter int                DEPTH     = 1024,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  word_count,
    output logic              full,
    output logic              inv_op,
    output logic [7:0]        inv_count
);

    // Operation codes on the request side.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_BNE = 4'd8;
    localparam logic [3:0] OP_J   = 4'd9;

    // MIPS32 primary opcodes.
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // Only ops 0..9 have an encoding. Everything above is dropped and counted.
    function automatic logic op_is_valid(input logic [3:0] f_op);
        logic ok;
        case (f_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Build the 32-bit instruction word. Fields that an op does not use are ignored.
    function automatic logic [31:0] encode(
        input logic [3:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (f_op)
            OP_ADD:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'h00, FN_ADD};
            OP_SUB:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'h00, FN_SUB};
            OP_AND:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'h00, FN_AND};
            OP_OR:   w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'h00, FN_OR};
            OP_SLT:  w = {OPC_RTYPE, f_rs, f_rt, f_rd, 5'h00, FN_SLT};
            OP_LW:   w = {OPC_LW,  f_rs, f_rt, f_imm};
            OP_SW:   w = {OPC_SW,  f_rs, f_rt, f_imm};
            OP_BEQ:  w = {OPC_BEQ, f_rs, f_rt, f_imm};
            OP_BNE:  w = {OPC_BNE, f_rs, f_rt, f_imm};
            OP_J:    w = {OPC_J, f_target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // State registers.
    logic              out_valid_r;
    logic [31:0]       out_word_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [CNT_W-1:0]  word_count_r;
    logic              full_r;
    logic              inv_op_r;
    logic [7:0]        inv_count_r;

    // Combinational helpers.
    logic              in_ready_s;
    logic              accept_s;
    logic              op_ok_s;
    logic              accept_word_s;
    logic              accept_inv_s;
    logic              drain_s;
    logic [31:0]       word_next_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic [7:0]        inv_count_next_s;

    // Handshake qualification, encoding and next-value arithmetic.
    always_comb begin
        in_ready_s       = 1'b0;
        accept_s         = 1'b0;
        op_ok_s          = 1'b0;
        accept_word_s    = 1'b0;
        accept_inv_s     = 1'b0;
        drain_s          = 1'b0;
        word_next_s      = 32'h0000_0000;
        addr_next_s      = BASE_ADDR;
        count_inc_s      = word_count_r;
        inv_count_next_s = inv_count_r;

        // Reset and restart both block acceptance. So does a full buffer or
        // an output that is stalled by the consumer.
        in_ready_s    = rst && !restart && !full_r && (!out_valid_r || out_ready);
        accept_s      = in_valid && in_ready_s;
        op_ok_s       = op_is_valid(op);
        accept_word_s = accept_s && op_ok_s;
        accept_inv_s  = accept_s && !op_ok_s;
        drain_s       = out_valid_r && out_ready;
        word_next_s   = encode(op, rs, rt, rd, imm, target);

        // The word address uses the count before this accept is added.
        // The sum wraps modulo 2^ADDR_W.
        addr_next_s = BASE_ADDR + ADDR_W'({word_count_r, 2'b00});
        count_inc_s = word_count_r + CNT_ONE;

        if (inv_count_r != 8'hFF) begin
            inv_count_next_s = inv_count_r + 8'd1;
        end else begin
            inv_count_next_s = inv_count_r;
        end
    end

    // Main state update. Priority is reset, then restart, then the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            out_word_r   <= 32'h0000_0000;
            out_addr_r   <= BASE_ADDR;
            word_count_r <= '0;
            full_r       <= 1'b0;
            inv_op_r     <= 1'b0;
            inv_count_r  <= 8'h00;
        end else if (restart) begin
            // The invalid-op count survives a restart. The last word stays on out_word.
            out_valid_r  <= 1'b0;
            out_addr_r   <= BASE_ADDR;
            word_count_r <= '0;
            full_r       <= 1'b0;
            inv_op_r     <= 1'b0;
        end else begin
            inv_op_r <= accept_inv_s;

            if (accept_word_s) begin
                out_valid_r  <= 1'b1;
                out_word_r   <= word_next_s;
                out_addr_r   <= addr_next_s;
                word_count_r <= count_inc_s;
                full_r       <= (count_inc_s == CNT_DEPTH);
            end else if (drain_s) begin
                // The word is consumed and no new word replaces it. out_word
                // and out_addr keep their last value.
                out_valid_r <= 1'b0;
            end

            if (accept_inv_s) begin
                inv_count_r <= inv_count_next_s;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_word   = out_word_r;
    assign out_addr   = out_addr_r;
    assign word_count = word_count_r;
    assign full       = full_r;
    assign inv_op     = inv_op_r;
    assign inv_count  = inv_count_r;

endmodule

// File: tb/tb_mips32_instr_encoder.sv
// Directed self-checking bench for mips32_instr_encoder (DEPTH = 4).
// Inputs change 1 time unit after a rising edge. Outputs are checked after
// that change settles, which is away from the active edge.
module tb_mips32_instr_encoder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic              clk;
    logic              rst;
    logic              restart;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0]  word_count;
    logic              full;
    logic              inv_op;
    logic [7:0]        inv_count;

    int checks = 0;
    int errors = 0;

    mips32_instr_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .word_count(word_count),
        .full      (full),
        .inv_op    (inv_op),
        .inv_count (inv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge. Leave the bench 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        op = o; rs = s; rt = t; rd = d; imm = i; target = tg;
    endtask

    // Watchdog so that the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0);
        tick(); tick();

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word",  out_word, 32'h0000_0000);
        check("rst_out_addr",  out_addr, BASE);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_full",      {31'd0, full}, 32'd0);
        check("rst_inv_op",    {31'd0, inv_op}, 32'd0);
        check("rst_inv_count", {24'd0, inv_count}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD r3 = r1 + r2
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_word",  out_word, 32'h0022_1820);
        check("add_addr",  out_addr, 32'h0040_0000);
        check("add_count", 32'(word_count), 32'd1);
        tick();
        check("add_drained", {31'd0, out_valid}, 32'd0);
        check("add_drain_word_kept", out_word, 32'h0022_1820);

        // Restart clears the counter
        restart = 1'b1;
        #1;
        check("restart_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        restart = 1'b0;
        check("restart_count", 32'(word_count), 32'd0);
        check("restart_addr",  out_addr, BASE);

        // Back-to-back: LW then J
        set_req(4'd5, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'h0);
        in_valid = 1'b1;
        #1;
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        tick();
        check("lw_word", out_word, 32'h8FA8_FFFC);
        check("lw_addr", out_addr, 32'h0040_0000);
        set_req(4'd9, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h010_0000);
        #1;
        check("b2b_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        check("j_word",  out_word, 32'h0810_0000);
        check("j_addr",  out_addr, 32'h0040_0004);
        check("j_count", 32'(word_count), 32'd2);

        // Backpressure: BEQ r3, r4, 0x10 held while the consumer stalls
        set_req(4'd7, 5'd3, 5'd4, 5'd0, 16'h0010, 26'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_word",  out_word, 32'h0810_0000);
            check("bp_addr",  out_addr, 32'h0040_0004);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("beq_word",  out_word, 32'h1064_0010);
        check("beq_addr",  out_addr, 32'h0040_0008);
        check("beq_count", 32'(word_count), 32'd3);
        tick();
        check("beq_drained", {31'd0, out_valid}, 32'd0);
        check("beq_no_dup_count", 32'(word_count), 32'd3);

        // Invalid op 12
        set_req(4'd12, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("inv_pulse",   {31'd0, inv_op}, 32'd1);
        check("inv_novalid", {31'd0, out_valid}, 32'd0);
        check("inv_count1",  {24'd0, inv_count}, 32'd1);
        check("inv_wc",      32'(word_count), 32'd3);
        tick();
        check("inv_pulse_end", {31'd0, inv_op}, 32'd0);

        // 299 more invalid ops, 300 in total, so the count saturates
        in_valid = 1'b1;
        repeat (299) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inv_sat",    {24'd0, inv_count}, 32'd255);
        check("inv_sat_wc", 32'(word_count), 32'd3);

        // Capacity: restart, then five SUB r7 = r5 - r6
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_keeps_inv", {24'd0, inv_count}, 32'd255);
        set_req(4'd1, 5'd5, 5'd6, 5'd7, 16'h0000, 26'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sub_word", out_word, 32'h00A6_3822);
            check("sub_addr", out_addr, BASE + 32'(4 * i));
        end
        check("full_set",   {31'd0, full}, 32'd1);
        check("full_count", 32'(word_count), 32'd4);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("full_drain",        {31'd0, out_valid}, 32'd0);
        check("full_5th_stalled",  32'(word_count), 32'd4);
        check("full_ready_still",  {31'd0, in_ready}, 32'd0);

        // Restart with in_valid held: nothing is accepted in the restart cycle
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_full_clr",   {31'd0, full}, 32'd0);
        check("rs_count",      32'(word_count), 32'd0);
        check("rs_no_accept",  {31'd0, out_valid}, 32'd0);
        tick();
        check("rs_next_addr",  out_addr, BASE);
        check("rs_next_word",  out_word, 32'h00A6_3822);
        check("rs_next_count", 32'(word_count), 32'd1);
        in_valid = 1'b0;

        // Restart while the output is stalled. The simultaneous request is refused.
        out_ready = 1'b0;
        restart = 1'b1;
        set_req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0);
        in_valid = 1'b1;
        #1;
        check("rs_stall_ready", {31'd0, in_ready}, 32'd0);
        tick();
        restart = 1'b0;
        in_valid = 1'b0;
        check("rs_stall_valid", {31'd0, out_valid}, 32'd0);
        check("rs_stall_count", 32'(word_count), 32'd0);

        // Reset in the middle of a stream
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        check("or_word", out_word, 32'h0022_1825);
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_word",  out_word, 32'h0000_0000);
        check("mid_rst_addr",  out_addr, BASE);
        check("mid_rst_count", 32'(word_count), 32'd0);
        check("mid_rst_inv",   {24'd0, inv_count}, 32'd0);
        check("mid_rst_full",  {31'd0, full}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_instr_encoder.md
Name: mips32_instr_encoder

Overview:
- Inverse of the control-unit decode path. Accepts symbolic micro-op requests (operation code plus register, immediate and target fields) and emits 32-bit MIPS32 instruction words, each with the instruction-memory byte address it belongs at.
- Used as the program builder that fills instruction memory during bring-up and self-test.
- Valid/ready handshake on both sides, registered output, sequential address and word counting, and a capacity limit.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0040_0000, byte address of the first emitted word.
- DEPTH, 1024, maximum number of words emitted before the block reports full.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- restart  in  1  synchronous clear: resets the address/word counter and drops any pending output.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J; 10–15 invalid.
- rs  in  5  source register.
- rt  in  5  target register.
- rd  in  5  destination register.
- imm  in  16  immediate / branch offset.
- target  in  26  jump target field.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_word.
- word_count  out  clog2(DEPTH+1)  words accepted since reset/restart.
- full  out  1  word_count == DEPTH.
- inv_op  out  1  one-cycle pulse: an invalid op was accepted and dropped.
- inv_count  out  8  saturating count of invalid ops.

Behaviour:
- Reset (rst==0 at edge): out_valid=0, out_word=0, out_addr=BASE_ADDR, word_count=0, full=0, inv_op=0, inv_count=0.
- in_ready = rst && !restart && !full && (!out_valid || out_ready). This is combinational and gives full throughput (one word per cycle) when the consumer is always ready.
- Encoding, registered one cycle after acceptance (latency 1).
  - R-type (ops 0–4): {6'h00, rs, rt, rd, 5'h00, funct}.
  - funct values: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2B, rs, rt, imm}.
  - BEQ: {6'h04, rs, rt, imm}.
  - BNE: {6'h05, rs, rt, imm}.
  - J: {6'h02, target}.
  - Fields not used by the op are ignored.
- Valid op accepted:
  - out_valid<=1, out_word<=encoding.
  - out_addr<=BASE_ADDR + 4*word_count, using the pre-increment value.
  - word_count<=word_count+1.
  - full is asserted the cycle after the DEPTH-th accept.
- Invalid op accepted:
  - No word is emitted and word_count is unchanged.
  - inv_op=1 for exactly one cycle.
  - inv_count increments and saturates at 255.
  - If out_valid was set and out_ready was high in the same cycle, out_valid goes to 0.
- Output hold: while out_valid && !out_ready, out_word and out_addr are stable and in_ready=0.
- Output drain: out_valid && out_ready with no new valid accept → out_valid<=0. out_word and out_addr keep their last value.
- restart=1 at an edge:
  - word_count<=0, full<=0, out_valid<=0, out_addr<=BASE_ADDR.
  - inv_count is preserved.
  - No input is accepted that cycle, even if in_valid=1.
- Full: in_ready stays low until restart or reset. A pending output may still drain.
- Address arithmetic is modulo 2^ADDR_W. No wrap check is made beyond DEPTH.
- Priority: rst > restart > handshake.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 with out_ready=1 → one cycle later out_word=32'h0022_1820, out_addr=32'h0040_0000, word_count=1.
- Back-to-back LW rs=29 rt=8 imm=16'hFFFC, then J target=26'h010_0000 → 32'h8FA8_FFFC @0x0040_0000, then 32'h0810_0000 @0x0040_0004; in_ready held high throughout.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_word/out_addr stable. On release, the next word is emitted at addr+4 with no loss or duplication.
- op=12 → inv_op pulses once, no out_valid, word_count unchanged; 300 invalid ops → inv_count=255.
- DEPTH=4: five SUB requests → 4 words emitted at addresses 0x...00–0x...0C, full=1, 5th request stalled. restart → next word emitted at BASE_ADDR, full=0.
- restart asserted while out_valid=1 and out_ready=0 → out_valid=0 next cycle, simultaneous in_valid not accepted. rst low mid-stream → all outputs return to reset values.
